// File: rtl/seg7_scan_capture_pkg.sv
// Shared segment pattern definitions and capture FSM states for the BCD-to-7-segment path.
// The encoder-side scanner uses these same patterns.
package seg7_scan_capture_pkg;

  // Patterns are active-low and ordered {a,b,c,d,e,f,g}.
  localparam logic [6:0] SEG7_P0    = 7'b0000001;
  localparam logic [6:0] SEG7_P1    = 7'b1001111;
  localparam logic [6:0] SEG7_P2    = 7'b0010010;
  localparam logic [6:0] SEG7_P3    = 7'b0000110;
  localparam logic [6:0] SEG7_P4    = 7'b1001100;
  localparam logic [6:0] SEG7_P5    = 7'b0100100;
  localparam logic [6:0] SEG7_P6    = 7'b0100000;
  localparam logic [6:0] SEG7_P7    = 7'b0001111;
  localparam logic [6:0] SEG7_P8    = 7'b0000000;
  localparam logic [6:0] SEG7_P9    = 7'b0000100;
  localparam logic [6:0] SEG7_BLANK = 7'b1111111;

  localparam logic [3:0] SEG7_BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational reverse lookup from an active-low segment pattern to BCD.
// A blank display decodes to the blank code and still counts as valid.
module seg7_pattern_decode
  import seg7_scan_capture_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       ok
);

  always_comb begin
    bcd = SEG7_BLANK_CODE;
    ok  = 1'b1;
    case (seg)
      SEG7_P0:    bcd = 4'd0;
      SEG7_P1:    bcd = 4'd1;
      SEG7_P2:    bcd = 4'd2;
      SEG7_P3:    bcd = 4'd3;
      SEG7_P4:    bcd = 4'd4;
      SEG7_P5:    bcd = 4'd5;
      SEG7_P6:    bcd = 4'd6;
      SEG7_P7:    bcd = 4'd7;
      SEG7_P8:    bcd = 4'd8;
      SEG7_P9:    bcd = 4'd9;
      SEG7_BLANK: bcd = SEG7_BLANK_CODE;
      default:    ok  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Samples a scanned 7-segment bus, debounces each digit and keeps a BCD image of the display.
// Optional SEG7_SCAN_CAPTURE_ERRCNT_EN adds a saturating count of invalid stable patterns.
module seg7_scan_capture
  import seg7_scan_capture_pkg::*;
#(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        seg,
  input  logic [NDIG-1:0]   dig_sel,
  output logic [4*NDIG-1:0] bcd,
  output logic [NDIG-1:0]   dig_valid,
  output logic              upd,
  output logic [2:0]        upd_idx,
  output logic              err
`ifdef SEG7_SCAN_CAPTURE_ERRCNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYC);

  logic [6:0]      seg_q, seg_p;
  logic [NDIG-1:0] sel_q, sel_p;
  state_t          state, state_nxt;
  logic [7:0]      cnt, cnt_nxt, cnt_inc;
  logic [3:0]      ones;
  logic            onehot, same, capture, reject;
  logic [2:0]      idx;
  logic [3:0]      dec_bcd;
  logic            dec_ok;

  seg7_pattern_decode u_decode (
    .seg (seg_q),
    .bcd (dec_bcd),
    .ok  (dec_ok)
  );

  // Two-deep sample history: every stability decision compares registered samples only.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= SEG7_BLANK;
      seg_p <= SEG7_BLANK;
      sel_q <= '0;
      sel_p <= '0;
    end else begin
      seg_q <= seg;
      seg_p <= seg_q;
      sel_q <= dig_sel;
      sel_p <= sel_q;
    end
  end

  always_comb begin
    ones = 4'd0;
    idx  = 3'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (sel_q[i]) begin
        ones = ones + 4'd1;
        idx  = 3'(i);
      end
    end
    onehot = (ones == 4'd1);
    same   = (seg_q == seg_p) && (sel_q == sel_p);
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cnt_inc   = cnt + 8'd1;
    capture   = 1'b0;
    reject    = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = 8'd0;
        if (onehot) begin
          state_nxt = TRACK;
          cnt_nxt   = 8'd1;
        end
      end
      TRACK: begin
        if (!onehot) begin
          state_nxt = IDLE;
          cnt_nxt   = 8'd0;
        end else if (!same) begin
          cnt_nxt = 8'd1;
        end else begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == STABLE_LIM) begin
            state_nxt = HOLD;
            capture   = dec_ok;
            reject    = !dec_ok;
          end
        end
      end
      HOLD: begin
        if (!onehot) begin
          state_nxt = IDLE;
          cnt_nxt   = 8'd0;
        end else if (!same) begin
          state_nxt = TRACK;
          cnt_nxt   = 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A capture is only ever raised with a one-hot select, so exactly one digit slot is written.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd       <= {NDIG{SEG7_BLANK_CODE}};
      dig_valid <= '0;
      upd       <= 1'b0;
      upd_idx   <= 3'd0;
      err       <= 1'b0;
    end else begin
      upd <= capture;
      if (capture) begin
        upd_idx <= idx;
        for (int i = 0; i < NDIG; i++) begin
          if (sel_q[i]) begin
            bcd[4*i +: 4] <= dec_bcd;
            dig_valid[i]  <= 1'b1;
          end
        end
      end
      if (reject) begin
        err <= 1'b1;
      end
    end
  end

`ifdef SEG7_SCAN_CAPTURE_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= 8'd0;
    end else if (reject && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Scoreboard bench for seg7_scan_capture (NDIG=4, STABLE_CYC=4).
// Define SEG7_SCAN_CAPTURE_ERRCNT_EN to also exercise err_cnt.
module tb_seg7_scan_capture;

  localparam logic [6:0] PAT0  = 7'b0000001;
  localparam logic [6:0] PAT2  = 7'b0010010;
  localparam logic [6:0] PAT3  = 7'b0000110;
  localparam logic [6:0] PAT4  = 7'b1001100;
  localparam logic [6:0] PAT5  = 7'b0100100;
  localparam logic [6:0] PAT7  = 7'b0001111;
  localparam logic [6:0] PAT8  = 7'b0000000;
  localparam logic [6:0] PAT9  = 7'b0000100;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] BAD   = 7'b1110000;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg;
  logic [3:0]  dig_sel;
  logic [15:0] bcd;
  logic [3:0]  dig_valid;
  logic        upd;
  logic [2:0]  upd_idx;
  logic        err;
`ifdef SEG7_SCAN_CAPTURE_ERRCNT_EN
  logic [7:0]  err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] idx;
    logic [3:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  logic upd_prev = 1'b0;

  seg7_scan_capture #(.NDIG(4), .STABLE_CYC(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .seg       (seg),
    .dig_sel   (dig_sel),
    .bcd       (bcd),
    .dig_valid (dig_valid),
    .upd       (upd),
    .upd_idx   (upd_idx),
    .err       (err)
`ifdef SEG7_SCAN_CAPTURE_ERRCNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every upd pulse must match the oldest pending capture.
  always @(negedge clk) begin
    if (upd === 1'b1) begin
      checks++;
      if (upd_prev) begin
        errors++;
        $display("[TB] FAIL upd_double: upd high on two consecutive cycles, idx=%0d", upd_idx);
      end else if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL upd_unexpected: got upd idx=%0d bcd=%h, required no upd", upd_idx, bcd);
      end else begin
        cur = sb.pop_front();
        if (upd_idx !== cur.idx || bcd[4*cur.idx +: 4] !== cur.val || dig_valid[cur.idx] !== 1'b1) begin
          errors++;
          $display("[TB] FAIL upd_capture: got idx=%0d digit=%h valid=%b, required idx=%0d digit=%h valid=1",
                   upd_idx, bcd[4*cur.idx +: 4], dig_valid[cur.idx], cur.idx, cur.val);
        end
      end
    end
    upd_prev = (upd === 1'b1);
  end

  task automatic hold_inputs(input logic [3:0] sel, input logic [6:0] s, input int n);
    dig_sel = sel;
    seg     = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_cap(input logic [2:0] i, input logic [3:0] v);
    exp_t e;
    e.idx = i;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bcd !== 16'hFFFF || dig_valid !== 4'b0000 || upd !== 1'b0 || upd_idx !== 3'd0 || err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_values: bcd=%h valid=%b upd=%b idx=%0d err=%b, required FFFF 0000 0 0 0",
               bcd, dig_valid, upd, upd_idx, err);
    end
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_single_digit();
    expect_cap(3'd0, 4'd2);
    dig_sel = 4'b0001;
    seg     = PAT2;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (upd !== (k == 5)) begin
        errors++;
        $display("[TB] FAIL single_latency: cycle %0d upd=%b, required %b", k, upd, (k == 5));
      end
    end
    checks++;
    if (bcd[3:0] !== 4'd2 || dig_valid !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL single_image: digit0=%h valid=%b, required 2 0001", bcd[3:0], dig_valid);
    end
    hold_inputs(4'b0000, BLANK, 2);
  endtask

  task automatic test_full_scan();
    expect_cap(3'd0, 4'd9);
    expect_cap(3'd1, 4'd7);
    expect_cap(3'd2, 4'hF);
    expect_cap(3'd3, 4'd0);
    hold_inputs(4'b0001, PAT9, 6);
    hold_inputs(4'b0010, PAT7, 6);
    hold_inputs(4'b0100, BLANK, 6);
    hold_inputs(4'b1000, PAT0, 6);
    hold_inputs(4'b0000, BLANK, 2);
    checks++;
    if (bcd !== 16'h0F79 || dig_valid !== 4'b1111 || err !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL full_scan: bcd=%h valid=%b err=%b pending=%0d, required 0F79 1111 0 0",
               bcd, dig_valid, err, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_glitch();
    expect_cap(3'd1, 4'd8);
    hold_inputs(4'b0010, PAT5, 3);
    hold_inputs(4'b0010, PAT8, 6);
    hold_inputs(4'b0000, BLANK, 2);
    checks++;
    if (bcd[7:4] !== 4'd8 || sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL glitch_filter: digit1=%h pending=%0d, required 8 0", bcd[7:4], sb.size());
      sb.delete();
    end
  endtask

  task automatic test_back_to_back();
    expect_cap(3'd1, 4'd2);
    expect_cap(3'd1, 4'd4);
    hold_inputs(4'b0010, PAT2, 6);
    hold_inputs(4'b0010, PAT4, 6);
    hold_inputs(4'b0000, BLANK, 2);
    checks++;
    if (bcd !== 16'h0F49 || dig_valid !== 4'b1111 || sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL overwrite: bcd=%h valid=%b pending=%0d, required 0F49 1111 0",
               bcd, dig_valid, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_non_onehot();
    int seen = 0;
    dig_sel = 4'b0110;
    seg     = PAT3;
    for (int k = 0; k < 20; k++) begin
      if (k == 10) dig_sel = 4'b0000;
      @(posedge clk);
      #1;
      if (upd === 1'b1) seen++;
    end
    checks++;
    if (seen != 0 || bcd !== 16'h0F49) begin
      errors++;
      $display("[TB] FAIL non_onehot: upd_count=%0d bcd=%h, required 0 0F49", seen, bcd);
    end
  endtask

  task automatic test_invalid();
    pulse_reset();
    hold_inputs(4'b0100, BAD, 5);
    hold_inputs(4'b0000, BLANK, 3);
    checks++;
    if (err !== 1'b1 || bcd[11:8] !== 4'hF || dig_valid[2] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL invalid_pattern: err=%b digit2=%h valid2=%b, required 1 F 0",
               err, bcd[11:8], dig_valid[2]);
    end
`ifdef SEG7_SCAN_CAPTURE_ERRCNT_EN
    checks++;
    if (err_cnt !== 8'd1) begin
      errors++;
      $display("[TB] FAIL err_cnt: got %0d, required 1", err_cnt);
    end
`endif
    expect_cap(3'd2, 4'd9);
    hold_inputs(4'b0100, PAT9, 6);
    hold_inputs(4'b0000, BLANK, 2);
    checks++;
    if (err !== 1'b1 || dig_valid !== 4'b0100 || sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL err_sticky: err=%b valid=%b pending=%0d, required 1 0100 0",
               err, dig_valid, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset_mid_track();
    hold_inputs(4'b1000, PAT3, 4);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bcd !== 16'hFFFF || dig_valid !== 4'b0000 || upd !== 1'b0 || upd_idx !== 3'd0 || err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_track: bcd=%h valid=%b upd=%b idx=%0d err=%b, required FFFF 0000 0 0 0",
               bcd, dig_valid, upd, upd_idx, err);
    end
`ifdef SEG7_SCAN_CAPTURE_ERRCNT_EN
    checks++;
    if (err_cnt !== 8'd0) begin
      errors++;
      $display("[TB] FAIL err_cnt_reset: got %0d, required 0", err_cnt);
    end
`endif
    rst = 1'b0;
    sb.delete();
    expect_cap(3'd3, 4'd3);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (upd !== (k == 5)) begin
        errors++;
        $display("[TB] FAIL post_reset_latency: cycle %0d upd=%b, required %b", k, upd, (k == 5));
      end
    end
    checks++;
    if (bcd !== 16'h3FFF || dig_valid !== 4'b1000 || sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL post_reset_image: bcd=%h valid=%b pending=%0d, required 3FFF 1000 0",
               bcd, dig_valid, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    rst     = 1'b1;
    seg     = BLANK;
    dig_sel = 4'b0000;
    @(posedge clk);
    #1;
    test_reset();
    test_single_digit();
    test_full_scan();
    test_glitch();
    test_back_to_back();
    test_non_onehot();
    test_invalid();
    test_reset_mid_track();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Receive side of the team's BCD-to-7-segment path.
- Samples a multiplexed, active-low 7-segment bus plus one-hot digit select, which is the output of a display scanner built on the BCD encoder.
- Decodes each digit pattern back to BCD once it has been stable for a programmable number of cycles, and holds a register image of all scanned digits.
- Used as a loopback checker on the display path and as a front end for reading external segment displays.

Parameters:
- NDIG, 4, number of scanned digits (1..8).
- STABLE_CYC, 4, consecutive identical samples required before acceptance (2..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- seg  in  7  segment bus, active-low (0 = lit); seg[6]=a, seg[5]=b, seg[4]=c, seg[3]=d, seg[2]=e, seg[1]=f, seg[0]=g.
- dig_sel  in  NDIG  digit enable, active-high, one-hot while scanning.
- bcd  out  4*NDIG  captured digits; digit i occupies bcd[4i+3:4i].
- dig_valid  out  NDIG  digit i holds a valid capture (0–9 or blank).
- upd  out  1  one-cycle pulse on each accepted capture.
- upd_idx  out  3  index of the digit captured; meaningful only when upd=1.
- err  out  1  sticky; set on any stable, unrecognised pattern.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high, and overrides everything on the same edge.
- Reset values: bcd=all 4'hF, dig_valid=0, upd=0, upd_idx=0, err=0, FSM=IDLE, stability counter=0.
- Inputs are registered once (sample stage) before any comparison.
- Decode table, seg[6:0] → bcd:
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4
  - 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9
  - 1111111→4'hF (blank, valid)
  - any other pattern is invalid.
- FSM:
  - IDLE: sampled dig_sel not exactly one-hot. Counter cleared. Go to TRACK when dig_sel becomes one-hot.
  - TRACK: a sample equal to the previous sample (both seg and dig_sel) increments the counter; any change reloads the counter to 1. When the counter reaches STABLE_CYC:
    - valid pattern: write bcd[idx], set dig_valid[idx], pulse upd with upd_idx=idx, go to HOLD.
    - invalid pattern: set err, leave bcd and dig_valid[idx] unchanged, go to HOLD.
  - HOLD: no further capture while inputs are unchanged. Any change in seg or dig_sel → TRACK with counter=1; dig_sel not one-hot → IDLE.
- Latency:
  - First accepted sample lands 1 cycle after the input edge (sample stage).
  - upd asserts STABLE_CYC cycles after the first stable sample is registered, i.e. STABLE_CYC+1 clocks after the inputs settle.
- upd is never high on two consecutive cycles for the same held pattern.
- A digit that changes to a new valid pattern is overwritten in place. Its dig_valid stays 1.
- err clears only on rst.
- Reset during TRACK or HOLD drops any partial count. No upd is produced on the reset edge.
- dig_sel index ≥ NDIG cannot occur, because the port width is NDIG.

Optional Feature:
- Macro: SEG7_SCAN_CAPTURE_ERRCNT_EN.
- Defined: adds output err_cnt (8 bits).
  - Increments on each invalid stable capture and saturates at 255.
  - Cleared by rst.
  - Invalid capture and reset on the same cycle: reset wins.
- Undefined: no err_cnt port and no counter logic; err behaviour unchanged.

Decomposition:
- Shared include file seg7_defs.vh holds:
  - the ten digit patterns and the blank pattern as localparams SEG7_P0..SEG7_P9 and SEG7_BLANK;
  - the blank code 4'hF;
  - FSM state encodings (IDLE=2'd0, TRACK=2'd1, HOLD=2'd2).
- The encoder-side scanner shares the same pattern file.
- One sub-module: seg7_pattern_decode, combinational. seg[6:0] in; bcd[3:0] and ok out.
- Top level holds the sample stage, FSM, counter, one-hot check and the register image.

Test Plan:
- Digit 0 only, NDIG=4, STABLE_CYC=4:
  - Stimulus: dig_sel=0001, seg=0010010, held 10 cycles.
  - Required: single upd at cycle 5 after the input edge, upd_idx=0, bcd[3:0]=2, dig_valid=0001.
- Full scan:
  - Stimulus: dig_sel cycles 0001→1000, 6 cycles each; seg = patterns for 9, 7, blank, 0.
  - Required: four upd pulses; bcd=16'h0F79; dig_valid=1111; err=0.
- Glitch filter:
  - Stimulus: pattern for 5 held 3 cycles, then 8 held 6 cycles, dig_sel=0010.
  - Required: no capture of 5; bcd[7:4]=8 captured once.
- Invalid pattern:
  - Stimulus: seg=1110000 stable 5 cycles on digit 2.
  - Required: err=1; bcd[11:8] unchanged (4'hF); dig_valid[2]=0; err_cnt=1 when the macro is defined.
- Non-one-hot select:
  - Stimulus: dig_sel=0110 or 0000 for 10 cycles with a valid seg.
  - Required: no upd; FSM stays IDLE.
- Reset mid-TRACK:
  - Stimulus: rst=1 for one cycle at count=3, then the same pattern continues.
  - Required: all outputs at reset values; next upd 5 cycles after rst deasserts; no upd on the reset cycle.
